cvbs_mix: RTL

CVBS_MIX -- requirements
Module: cvbs_mix

---
 rtl/cvbs_pkg.sv | 30 +++
 rtl/cvbs_sat.sv | 21 ++
 rtl/cvbs_mix.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cvbs_pkg.sv
// Shared types and constants for the composite video mixer.
// Holds the line-timing state encoding and the luma/chroma scaling helpers.
package cvbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_BPORCH = 2'd2,
        ST_ACTIVE = 2'd3
    } cvbs_state_t;

    localparam int         CNT_W      = 12;
    localparam logic [7:0] LUMA_GAIN  = 8'd183;
    localparam logic [8:0] CHROMA_OFS = 9'd128;

    // Luma scaled so full-scale Y fits between blank and DAC full scale.
    function automatic logic [7:0] luma_term(input logic [7:0] y);
        logic [15:0] p;
        p = {8'd0, y} * {8'd0, LUMA_GAIN};
        return p[15:8];
    endfunction

    // Offset-binary chroma re-centred on zero and halved (arithmetic shift).
    function automatic logic signed [9:0] chroma_term(input logic [7:0] c);
        logic signed [9:0] d;
        d = $signed({2'b00, c}) - $signed({1'b0, CHROMA_OFS});
        return d >>> 1;
    endfunction

endpackage

// File: rtl/cvbs_sat.sv
// Clamp of the signed composite sum into the unsigned 8-bit DAC range.
// Purely combinational; the caller registers the result.
module cvbs_sat
    import cvbs_pkg::*;
(
    input  logic signed [9:0] sum,
    output logic [7:0]        code
);

    // Bit 9 flags a negative sum, bit 8 (with bit 9 clear) a sum above 255.
    always_comb begin
        if (sum[9]) begin
            code = 8'd0;
        end else if (sum[8]) begin
            code = 8'd255;
        end else begin
            code = sum[7:0];
        end
    end

endmodule

// File: rtl/cvbs_mix.sv
// Composite video mixer: 3-stage pipeline (register, sum, clamp) with line-timing FSM.
// Chroma is added only when CVBS_CHROMA_EN is defined; otherwise output is monochrome.
module cvbs_mix
    import cvbs_pkg::*;
#(
    parameter logic [7:0] BLANK_LVL = 8'd72,
    parameter int         BP_LEN    = 240,
    parameter int         LINE_TMO  = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] din,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        csync,
    output logic [7:0]  cvbs_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        csync_o,
    output logic        lost_o,
    output logic [1:0]  state_o
);

    localparam logic [CNT_W-1:0] LINE_CAP = CNT_W'(LINE_TMO);
    localparam logic [CNT_W-1:0] BP_LAST  = CNT_W'(BP_LEN - 1);
    localparam logic signed [9:0] BLANK10 = {2'b00, BLANK_LVL};

    logic [7:0] y_s1;
    logic       hs_s1, vs_s1, cs_s1, cs_prev;
`ifdef CVBS_CHROMA_EN
    logic [7:0] c_s1;
    logic       unused_din;
    assign unused_din = ^din[7:0];
`else
    logic       unused_din;
    assign unused_din = ^{din[23:16], din[7:0]};
`endif

    // Stage 1: input register plus previous csync for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_s1    <= '0;
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
            cs_s1   <= 1'b0;
            cs_prev <= 1'b0;
`ifdef CVBS_CHROMA_EN
            c_s1    <= '0;
`endif
        end else begin
            y_s1    <= din[15:8];
            hs_s1   <= hsync;
            vs_s1   <= vsync;
            cs_s1   <= csync;
            cs_prev <= cs_s1;
`ifdef CVBS_CHROMA_EN
            c_s1    <= din[23:16];
`endif
        end
    end

    cvbs_state_t      state_q, state_d;
    logic [CNT_W-1:0] line_q, line_d, porch_q, porch_d;
    logic             lost_q, lost_d;
    logic             cs_rise, cs_fall, tmo;

    assign cs_rise = cs_s1 & ~cs_prev;
    assign cs_fall = ~cs_s1 & cs_prev;
    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            porch_q <= '0;
            lost_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            porch_q <= porch_d;
            lost_q  <= lost_d;
        end
    end

    // state_d is the state of the sample now in stage 1; it drives the stage-2 sum.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        porch_d = porch_q;
        lost_d  = lost_q;
        tmo     = 1'b0;

        if (cs_rise) begin
            line_d = '0;
        end else if (line_q != LINE_CAP) begin
            line_d = line_q + CNT_W'(1);
        end
        tmo = !cs_rise && (line_d == LINE_CAP);

        case (state_q)
            ST_SYNC: begin
                if (cs_fall) begin
                    state_d = ST_BPORCH;
                    porch_d = '0;
                end
            end
            ST_BPORCH: begin
                if (porch_q == BP_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    porch_d = porch_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (tmo) begin
            state_d = ST_IDLE;
            lost_d  = 1'b1;
        end
        if (cs_rise) begin
            state_d = ST_SYNC;
            lost_d  = 1'b0;
        end
    end

    logic signed [9:0] l10, k10, sum_d, sum_q;
    assign l10 = {2'b00, luma_term(y_s1)};
`ifdef CVBS_CHROMA_EN
    assign k10 = chroma_term(c_s1);
`else
    assign k10 = '0;
`endif

    always_comb begin
        sum_d = BLANK10;
        case (state_d)
            ST_SYNC:   sum_d = '0;
            ST_BPORCH: sum_d = BLANK10 + k10;
            ST_ACTIVE: if (!vs_s1) sum_d = BLANK10 + l10 + k10;
            default:   ;
        endcase
    end

    logic hs_s2, vs_s2, cs_s2;
    logic [7:0] sat_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= BLANK10;
            hs_s2 <= 1'b0;
            vs_s2 <= 1'b0;
            cs_s2 <= 1'b0;
        end else begin
            sum_q <= sum_d;
            hs_s2 <= hs_s1;
            vs_s2 <= vs_s1;
            cs_s2 <= cs_s1;
        end
    end

    cvbs_sat u_sat (
        .sum  (sum_q),
        .code (sat_code)
    );

    // Stage 3: clamp result and the matching sync/lock flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cvbs_o  <= BLANK_LVL;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            csync_o <= 1'b0;
            lost_o  <= 1'b1;
        end else begin
            cvbs_o  <= sat_code;
            hsync_o <= hs_s2;
            vsync_o <= vs_s2;
            csync_o <= cs_s2;
            lost_o  <= lost_q;
        end
    end

endmodule
